// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : SDRAM command encodings, init-sequencer states and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] c_CMD_DESELECT  = 4'b1111;
    localparam logic [3:0] c_CMD_NOP       = 4'b0111;
    localparam logic [3:0] c_CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] c_CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] c_CMD_LOAD_MODE = 4'b0000;

    localparam logic [11:0] c_MODE_REG_DEFAULT  = 12'h033;
    localparam logic [11:0] c_ADDR_PRECHARGE_ALL = 12'h400;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK = 4'd0,
        ST_POWERUP   = 4'd1,
        ST_PRECHARGE = 4'd2,
        ST_WAIT_RP   = 4'd3,
        ST_REFRESH   = 4'd4,
        ST_WAIT_RFC  = 4'd5,
        ST_LOAD_MODE = 4'd6,
        ST_WAIT_MRD  = 4'd7,
        ST_DONE      = 4'd8
    } init_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_init_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_seq_if
// Description : SDRAM command bus driven by the power-up init sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_init_seq_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic        init_done;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done
    );
endinterface
`default_nettype wire

// File: rtl/sdram_lock_sync.sv
`default_nettype none
// ============================================================================
// Module      : sdram_lock_sync
// Description : 2-flop synchronizer plus saturating filter for a PLL lock flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_lock_sync #(
    parameter int LOCK_FILTER = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic async_i,
    output logic      sync_o,
    output logic      lock_ok_o
);

    localparam int              c_FW       = $clog2(LOCK_FILTER + 1);
    localparam logic [c_FW-1:0] c_FILT_MAX = c_FW'(LOCK_FILTER);

    logic            meta_q;
    logic            sync_q;
    logic [c_FW-1:0] filt_q;
    logic [c_FW-1:0] filt_d;

    // Any low sample restarts the qualification window.
    always_comb begin
        filt_d = filt_q;
        if (!sync_q) begin
            filt_d = '0;
        end else if (filt_q != c_FILT_MAX) begin
            filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            filt_q <= filt_d;
        end
    end

    assign sync_o    = sync_q;
    assign lock_ok_o = (filt_q == c_FILT_MAX);

endmodule
`default_nettype wire

// File: rtl/sdram_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_seq
// Description : JEDEC SDR SDRAM power-up sequencer gated by a filtered PLL lock.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int          POWERUP_CYCLES = 20000,
    parameter int          LOCK_FILTER    = 16,
    parameter int          T_RP           = 2,
    parameter int          T_RFC          = 7,
    parameter int          T_MRD          = 2,
    parameter int          NUM_REFRESH    = 2,
    parameter logic [11:0] MODE_REG       = c_MODE_REG_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          pll_locked,
    sdram_init_seq_if.master   cmd_o
);

    localparam int c_WW = $clog2(POWERUP_CYCLES + 1);

    logic        lock_sync;
    logic        lock_ok;

    init_state_e     state_q, state_d;
    logic [c_WW-1:0] wait_q,  wait_d;
    logic [3:0]      ref_q,   ref_d;
    logic [3:0]      cmd_q,   cmd_d;
    logic [11:0]     addr_q,  addr_d;
    logic            cke_q,   cke_d;
    logic            done_q,  done_d;

    sdram_lock_sync #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_i   (pll_locked),
        .sync_o    (lock_sync),
        .lock_ok_o (lock_ok)
    );

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        wait_d  = (wait_q != '0) ? wait_q - 1'b1 : wait_q;

        if (!lock_sync) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: if (lock_ok)        state_d = ST_POWERUP;
                ST_POWERUP:   if (wait_q == '0)   state_d = ST_PRECHARGE;
                ST_PRECHARGE:                     state_d = ST_WAIT_RP;
                ST_WAIT_RP:   if (wait_q == '0)   state_d = ST_REFRESH;
                ST_REFRESH:                       state_d = ST_WAIT_RFC;
                ST_WAIT_RFC: begin
                    if (wait_q == '0) begin
                        state_d = (ref_q < 4'(NUM_REFRESH)) ? ST_REFRESH : ST_LOAD_MODE;
                    end
                end
                ST_LOAD_MODE:                     state_d = ST_WAIT_MRD;
                ST_WAIT_MRD:  if (wait_q == '0)   state_d = ST_DONE;
                ST_DONE:                          state_d = ST_DONE;
                default:                          state_d = ST_WAIT_LOCK;
            endcase
        end

        // The wait counter is loaded on the cycle a command is issued, so the
        // following wait state exits when it has counted down to zero.
        cmd_d  = c_CMD_NOP;
        addr_d = '0;
        case (state_d)
            ST_WAIT_LOCK: begin
                cmd_d  = c_CMD_DESELECT;
                wait_d = '0;
                ref_d  = '0;
            end
            ST_POWERUP: begin
                if (state_q != ST_POWERUP) wait_d = c_WW'(POWERUP_CYCLES - 1);
            end
            ST_PRECHARGE: begin
                cmd_d  = c_CMD_PRECHARGE;
                addr_d = c_ADDR_PRECHARGE_ALL;
                wait_d = c_WW'(T_RP - 1);
            end
            ST_REFRESH: begin
                cmd_d  = c_CMD_REFRESH;
                wait_d = c_WW'(T_RFC - 1);
                ref_d  = ref_q + 1'b1;
            end
            ST_LOAD_MODE: begin
                cmd_d  = c_CMD_LOAD_MODE;
                addr_d = MODE_REG;
                wait_d = c_WW'(T_MRD - 1);
            end
            default: ;
        endcase

        cke_d  = (state_d != ST_WAIT_LOCK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOCK;
            wait_q  <= '0;
            ref_q   <= '0;
            cmd_q   <= c_CMD_DESELECT;
            addr_q  <= '0;
            cke_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ref_q   <= ref_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            cke_q   <= cke_d;
            done_q  <= done_d;
        end
    end

    assign cmd_o.cke       = cke_q;
    assign cmd_o.cs_n      = cmd_q[3];
    assign cmd_o.ras_n     = cmd_q[2];
    assign cmd_o.cas_n     = cmd_q[1];
    assign cmd_o.we_n      = cmd_q[0];
    assign cmd_o.ba        = 2'b00;
    assign cmd_o.addr      = addr_q;
    assign cmd_o.init_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_init_seq
// Description : Directed self-checking bench for the SDRAM init sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_init_seq;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
    } ev_t;

    logic clk;
    logic rst_n;
    logic pll_locked;

    int checks;
    int failures;
    int cyc;

    ev_t  qa[$];
    ev_t  qb[$];
    int   cke_rise[2];
    int   done_rise[2];
    int   cke_falls[2];
    int   done_falls[2];
    logic cke_prev[2];
    logic done_prev[2];

    sdram_init_seq_if bus_a ();
    sdram_init_seq_if bus_b ();

    sdram_init_seq #(
        .POWERUP_CYCLES (100),
        .LOCK_FILTER    (4)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cmd_o      (bus_a)
    );

    sdram_init_seq #(
        .POWERUP_CYCLES (100),
        .LOCK_FILTER    (4),
        .T_RFC          (10),
        .NUM_REFRESH    (8)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cmd_o      (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] cmd_of(input bit which);
        if (which) return {bus_b.cs_n, bus_b.ras_n, bus_b.cas_n, bus_b.we_n};
        return {bus_a.cs_n, bus_a.ras_n, bus_a.cas_n, bus_a.we_n};
    endfunction

    task automatic clear_rec();
        qa.delete();
        qb.delete();
        cyc = 0;
        for (int w = 0; w < 2; w++) begin
            cke_rise[w]   = -1;
            done_rise[w]  = -1;
            cke_falls[w]  = 0;
            done_falls[w] = 0;
        end
        cke_prev[0]  = bus_a.cke;  cke_prev[1]  = bus_b.cke;
        done_prev[0] = bus_a.init_done; done_prev[1] = bus_b.init_done;
    endtask

    // Log every cycle that is not idle (DESELECT before cke, NOP after).
    task automatic rec(input bit which, input logic cke, input logic [3:0] cmd,
                       input logic [1:0] ba, input logic [11:0] addr, input logic done);
        ev_t        e;
        logic [3:0] idle;
        int         w;
        w      = which ? 1 : 0;
        idle   = (cke === 1'b1) ? 4'b0111 : 4'b1111;
        e.cyc  = cyc;
        e.cmd  = cmd;
        e.ba   = ba;
        e.addr = addr;
        if (cmd !== idle || addr !== 12'h000 || ba !== 2'b00) begin
            if (which) qb.push_back(e);
            else       qa.push_back(e);
        end
        if (cke === 1'b1 && cke_prev[w] !== 1'b1 && cke_rise[w] < 0) cke_rise[w] = cyc;
        if (cke !== 1'b1 && cke_prev[w] === 1'b1) cke_falls[w]++;
        if (done === 1'b1 && done_prev[w] !== 1'b1 && done_rise[w] < 0) done_rise[w] = cyc;
        if (done !== 1'b1 && done_prev[w] === 1'b1) done_falls[w]++;
        cke_prev[w]  = cke;
        done_prev[w] = done;
    endtask

    task automatic step_rec();
        @(posedge clk);
        #1;
        cyc++;
        rec(1'b0, bus_a.cke, cmd_of(1'b0), bus_a.ba, bus_a.addr, bus_a.init_done);
        rec(1'b1, bus_b.cke, cmd_of(1'b1), bus_b.ba, bus_b.addr, bus_b.init_done);
    endtask

    task automatic restart();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus_a.cke, cmd_of(1'b0), bus_a.ba, bus_a.addr, bus_a.init_done} !== {1'b0, 4'b1111, 2'b00, 12'h000, 1'b0}) begin
                failures++;
                $display("FAIL reset_a cyc=%0d got cke=%b cmd=%b ba=%0d addr=%h done=%b want cke=0 cmd=1111 ba=0 addr=000 done=0",
                         i, bus_a.cke, cmd_of(1'b0), bus_a.ba, bus_a.addr, bus_a.init_done);
            end
            checks++;
            if ({bus_b.cke, cmd_of(1'b1), bus_b.ba, bus_b.addr, bus_b.init_done} !== {1'b0, 4'b1111, 2'b00, 12'h000, 1'b0}) begin
                failures++;
                $display("FAIL reset_b cyc=%0d got cke=%b cmd=%b addr=%h done=%b want 0/1111/000/0",
                         i, bus_b.cke, cmd_of(1'b1), bus_b.addr, bus_b.init_done);
            end
        end
    endtask

    // Default config: cke@7, PRE@107, REF@109,116, LMR@123, done@125.
    task automatic test_sequence(input string tag);
        int          ec[4] = '{107, 109, 116, 123};
        logic [3:0]  em[4] = '{4'b0010, 4'b0001, 4'b0001, 4'b0000};
        logic [11:0] ea[4] = '{12'h400, 12'h000, 12'h000, 12'h033};
        repeat (140) step_rec();
        checks++;
        if (cke_rise[0] !== 7) begin
            failures++;
            $display("FAIL %s_cke_rise got %0d want 7", tag, cke_rise[0]);
        end
        checks++;
        if (qa.size() !== 4) begin
            failures++;
            $display("FAIL %s_cmd_count got %0d want 4", tag, qa.size());
        end
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            checks++;
            if (qa[i].cyc !== ec[i] || qa[i].cmd !== em[i] || qa[i].addr !== ea[i] || qa[i].ba !== 2'b00) begin
                failures++;
                $display("FAIL %s_cmd%0d got cyc=%0d cmd=%b addr=%h ba=%0d want cyc=%0d cmd=%b addr=%h ba=0",
                         tag, i, qa[i].cyc, qa[i].cmd, qa[i].addr, qa[i].ba, ec[i], em[i], ea[i]);
            end
        end
        checks++;
        if (done_rise[0] !== 125 || done_falls[0] !== 0 || cke_falls[0] !== 0) begin
            failures++;
            $display("FAIL %s_done got rise=%0d done_falls=%0d cke_falls=%0d want rise=125 falls=0/0",
                     tag, done_rise[0], done_falls[0], cke_falls[0]);
        end
    endtask

    task automatic test_glitch();
        restart();
        pll_locked = 1'b1;
        clear_rec();
        repeat (3) step_rec();
        pll_locked = 1'b0;
        repeat (40) step_rec();
        checks++;
        if (cke_rise[0] !== -1 || cke_rise[1] !== -1) begin
            failures++;
            $display("FAIL glitch_cke got rise_a=%0d rise_b=%0d want none", cke_rise[0], cke_rise[1]);
        end
        checks++;
        if (qa.size() !== 0 || qb.size() !== 0) begin
            failures++;
            $display("FAIL glitch_cmds got a=%0d b=%0d want 0 commands", qa.size(), qb.size());
        end
    endtask

    task automatic test_lock_loss();
        restart();
        pll_locked = 1'b1;
        clear_rec();
        repeat (112) step_rec();
        pll_locked = 1'b0;
        repeat (2) step_rec();
        checks++;
        if (bus_a.cke !== 1'b1) begin
            failures++;
            $display("FAIL loss_pre_cke cyc=%0d got %b want 1", cyc, bus_a.cke);
        end
        step_rec();
        checks++;
        if ({bus_a.cke, cmd_of(1'b0), bus_a.addr, bus_a.init_done} !== {1'b0, 4'b1111, 12'h000, 1'b0}) begin
            failures++;
            $display("FAIL loss_abort cyc=%0d got cke=%b cmd=%b addr=%h done=%b want 0/1111/000/0",
                     cyc, bus_a.cke, cmd_of(1'b0), bus_a.addr, bus_a.init_done);
        end
        checks++;
        if (bus_b.cke !== 1'b0 || cmd_of(1'b1) !== 4'b1111) begin
            failures++;
            $display("FAIL loss_abort_b got cke=%b cmd=%b want 0/1111", bus_b.cke, cmd_of(1'b1));
        end
        repeat (5) step_rec();
        pll_locked = 1'b1;
        clear_rec();
        test_sequence("relock");
    endtask

    task automatic test_async_reset();
        restart();
        pll_locked = 1'b1;
        clear_rec();
        repeat (50) step_rec();
        checks++;
        if (bus_a.cke !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_cke got %b want 1", bus_a.cke);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.cke, cmd_of(1'b0), bus_a.addr, bus_a.init_done} !== {1'b0, 4'b1111, 12'h000, 1'b0}) begin
            failures++;
            $display("FAIL areset_async got cke=%b cmd=%b addr=%h done=%b want 0/1111/000/0",
                     bus_a.cke, cmd_of(1'b0), bus_a.addr, bus_a.init_done);
        end
        pll_locked = 1'b0;
    endtask

    // NUM_REFRESH=8, T_RFC=10: PRE@107, REF@109+10k, LMR@189, done@191.
    task automatic test_num_refresh();
        int          ec;
        logic [3:0]  em;
        logic [11:0] ea;
        restart();
        pll_locked = 1'b1;
        clear_rec();
        repeat (200) step_rec();
        checks++;
        if (qb.size() !== 10) begin
            failures++;
            $display("FAIL nref_cmd_count got %0d want 10", qb.size());
        end
        for (int i = 0; i < 10 && i < qb.size(); i++) begin
            if (i == 0) begin
                ec = 107; em = 4'b0010; ea = 12'h400;
            end else if (i == 9) begin
                ec = 189; em = 4'b0000; ea = 12'h033;
            end else begin
                ec = 109 + 10 * (i - 1); em = 4'b0001; ea = 12'h000;
            end
            checks++;
            if (qb[i].cyc !== ec || qb[i].cmd !== em || qb[i].addr !== ea) begin
                failures++;
                $display("FAIL nref_cmd%0d got cyc=%0d cmd=%b addr=%h want cyc=%0d cmd=%b addr=%h",
                         i, qb[i].cyc, qb[i].cmd, qb[i].addr, ec, em, ea);
            end
        end
        checks++;
        if (done_rise[1] !== 191 || cke_rise[1] !== 7) begin
            failures++;
            $display("FAIL nref_done got done_rise=%0d cke_rise=%0d want 191/7", done_rise[1], cke_rise[1]);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;

        test_reset();
        restart();
        pll_locked = 1'b1;
        clear_rec();
        test_sequence("seq");
        test_glitch();
        test_lock_loss();
        test_async_reset();
        test_num_refresh();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
